mux4_rr_arbiter: RTL

//  Shares one 4:1 mux output channel (QuesFourMUX: inputs a..d, selects s1/s0)

---
 rtl/mux4_rr_arbiter_pkg.sv | 16 +
 rtl/mux4_rr_arbiter_if.sv | 15 +
 rtl/mux4_rr_arbiter_rr_pick.sv | 23 ++
 rtl/mux4_rr_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

   typedef logic [1:0] req_idx_t;

   // One-hot grant vector for a requester index.
   function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
// The arbiter also drives the shared mux selects and the ownership flags.
interface mux4_rr_arbiter_if;

   logic [mux_arb_pkg::NUM_REQ-1:0] req;
   logic [mux_arb_pkg::NUM_REQ-1:0] gnt;
   logic                            s1;
   logic                            s0;
   logic                            ch_valid;
   logic                            busy;

   modport master (output req, input gnt, s1, s0, ch_valid, busy);
   modport slave  (input req, output gnt, s1, s0, ch_valid, busy);

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request bit starting from ptr.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_idx_t           ptr,
   output logic               any,
   output req_idx_t           win
);

   // Scan from the farthest offset back to ptr so the closest request wins.
   always_comb begin
      any = 1'b0;
      win = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[ptr + req_idx_t'(i)]) begin
            any = 1'b1;
            win = ptr + req_idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux channel.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no owner; arbitrate among pending requests from ptr
//  GRANT   | one requester owns the mux; ends on req drop or hold limit
//  RELEASE | single dead cycle with no owner before arbitration resumes
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mux4_rr_arbiter_if.slave arb
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t HOLD_MAX = cnt_t'(MAX_HOLD);

   arb_state_t         state_q, state_d;
   req_idx_t           ptr_q, ptr_d;
   req_idx_t           sel_q, sel_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   cnt_t               hold_cnt_q, hold_cnt_d;
   logic               ch_valid_q, ch_valid_d;
   logic               busy_q, busy_d;

   logic               pick_any;
   req_idx_t           pick_win;

   rr_pick u_rr_pick (
      .req (arb.req),
      .ptr (ptr_q),
      .any (pick_any),
      .win (pick_win)
   );

   // Next-state: sel_q doubles as the current owner's index while in GRANT.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d      = sel_q;
      gnt_d      = gnt_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d    = GRANT;
               gnt_d      = onehot(pick_win);
               sel_d      = pick_win;
               hold_cnt_d = cnt_t'(1);
            end
         end
         GRANT: begin
            if (!arb.req[sel_q] || (hold_cnt_q == HOLD_MAX)) begin
               state_d    = RELEASE;
               gnt_d      = '0;
               ptr_d      = sel_q + req_idx_t'(1);
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + cnt_t'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
         end
      endcase
      ch_valid_d = (state_d == GRANT);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers, synchronously cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         sel_q      <= '0;
         gnt_q      <= '0;
         hold_cnt_q <= '0;
         ch_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         gnt_q      <= gnt_d;
         hold_cnt_q <= hold_cnt_d;
         ch_valid_q <= ch_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign arb.gnt      = gnt_q;
   assign arb.s1       = sel_q[1];
   assign arb.s0       = sel_q[0];
   assign arb.ch_valid = ch_valid_q;
   assign arb.busy     = busy_q;

endmodule
